// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: circular byte FIFO behind spislave, show-ahead read port.
// Define SPI_RX_FIFO_SOF_EN to tag the first byte of each ss frame.
module spi_rx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            rx_data,
   input  logic                  rx_rdy,
   input  logic                  ss,
   input  logic                  rd_en,
   output logic [7:0]            rd_data,
   output logic                  rd_sof,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  ovf,
   input  logic                  ovf_clr
);

   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

`ifdef SPI_RX_FIFO_SOF_EN
   localparam int EW = 9;
`else
   localparam int EW = 8;
`endif

   logic [EW-1:0]         r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  r_rdy_q;
   logic                  r_ovf;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_wr;
   logic                  w_drop;
   logic                  w_empty;
   logic                  w_full;
   logic [EW-1:0]         w_entry;
   logic [EW-1:0]         w_head;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_CNT);
   assign w_push  = rx_rdy & ~r_rdy_q;
   assign w_pop   = rd_en & ~w_empty;
   // A pop in the same cycle frees the head, so a full FIFO still accepts.
   assign w_wr    = w_push & (~w_full | w_pop);
   assign w_drop  = w_push & w_full & ~w_pop;
   assign w_head  = r_mem[r_rd_ptr];

   // Pointer, occupancy, edge-detect and sticky-overflow state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_rdy_q  <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_rdy_q <= rx_rdy;
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_wr && !w_pop)
            r_count <= r_count + 1'b1;
         else if (w_pop && !w_wr)
            r_count <= r_count - 1'b1;
         if (w_drop)
            r_ovf <= 1'b1;
         else if (ovf_clr)
            r_ovf <= 1'b0;
      end
   end

   // Storage array; contents survive reset, only the pointers are cleared.
   always_ff @(posedge clk) begin
      if (rst_n && w_wr)
         r_mem[r_wr_ptr] <= w_entry;
   end

`ifdef SPI_RX_FIFO_SOF_EN
   logic r_ss_q;
   logic r_sof_pend;
   logic w_ss_fall;

   assign w_ss_fall = r_ss_q & ~ss;
   // A frame start coinciding with a push tags that very byte.
   assign w_entry   = {r_sof_pend | w_ss_fall, rx_data};

   // Frame-start tracking: pending until a byte is actually stored.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ss_q     <= 1'b1;
         r_sof_pend <= 1'b0;
      end else begin
         r_ss_q <= ss;
         if (w_wr)
            r_sof_pend <= 1'b0;
         else if (w_ss_fall)
            r_sof_pend <= 1'b1;
      end
   end

   assign rd_data = w_empty ? 8'h00 : w_head[7:0];
   assign rd_sof  = ~w_empty & w_head[8];
`else
   logic w_unused_ss;

   assign w_unused_ss = ss;
   assign w_entry     = rx_data;
   assign rd_data     = w_empty ? 8'h00 : w_head;
   assign rd_sof      = 1'b0;
`endif

   assign empty = w_empty;
   assign full  = w_full;
   assign count = r_count;
   assign ovf   = r_ovf;

endmodule

// File: tb/tb_spi_rx_fifo.sv
// tb_spi_rx_fifo: directed scenarios plus random traffic,
// every cycle compared against a queue-based model.
module tb_spi_rx_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_rdy;
   logic       ss;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_sof;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       ovf;
   logic       ovf_clr;

   int n_chk = 0;
   int n_err = 0;

   logic [8:0] mq[$];
   logic       m_rdy_q;
   logic       m_ss_q;
   logic       m_pend;
   logic       m_ovf;

   spi_rx_fifo #(.DEPTH_LOG2(4)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rx_data (rx_data),
      .rx_rdy  (rx_rdy),
      .ss      (ss),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .rd_sof  (rd_sof),
      .empty   (empty),
      .full    (full),
      .count   (count),
      .ovf     (ovf),
      .ovf_clr (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: advance the model by the rules, then compare all outputs.
   task automatic cyc();
      bit push, pop, fall, drop, sof;
      @(posedge clk);
      push = rx_rdy && !m_rdy_q;
      pop  = rd_en && (mq.size() != 0);
      if (!rst_n) begin
         mq.delete();
         m_rdy_q = 1'b0;
         m_ss_q  = 1'b1;
         m_pend  = 1'b0;
         m_ovf   = 1'b0;
      end else begin
`ifdef SPI_RX_FIFO_SOF_EN
         fall = m_ss_q && !ss;
`else
         fall = 1'b0;
`endif
         sof  = m_pend || fall;
         drop = push && (mq.size() == 16) && !pop;
         if (pop)
            void'(mq.pop_front());
         if (push && !drop) begin
            mq.push_back({sof, rx_data});
            m_pend = 1'b0;
         end else if (fall) begin
            m_pend = 1'b1;
         end
         if (drop)
            m_ovf = 1'b1;
         else if (ovf_clr)
            m_ovf = 1'b0;
         m_rdy_q = rx_rdy;
         m_ss_q  = ss;
      end
      #1;
      chk("count", 32'(count), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == 16));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("rd_data", 32'(rd_data), mq.size() != 0 ? 32'(mq[0][7:0]) : 32'h0);
      chk("rd_sof", 32'(rd_sof), mq.size() != 0 ? 32'(mq[0][8]) : 32'h0);
   endtask

   task automatic push_byte(input logic [7:0] d);
      rx_data = d;
      rx_rdy  = 1'b1;
      cyc();
      rx_rdy  = 1'b0;
      cyc();
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_b;
      logic [3:0] sof_pat;
      rst_n   = 1'b0;
      rx_data = 8'h00;
      rx_rdy  = 1'b0;
      ss      = 1'b1;
      rd_en   = 1'b0;
      ovf_clr = 1'b0;
      m_rdy_q = 1'b0;
      m_ss_q  = 1'b1;
      m_pend  = 1'b0;
      m_ovf   = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
      chk("t1_empty", 32'(empty), 32'd1);
      chk("t1_count", 32'(count), 32'd0);
      rd_en = 1'b1;
      repeat (3) cyc();
      rd_en = 1'b0;
      chk("t1_rd_empty", 32'(empty), 32'd1);

      rx_data = 8'hDE;
      rx_rdy  = 1'b1;
      repeat (5) cyc();
      rx_rdy = 1'b0;
      cyc();
      chk("t2_count", 32'(count), 32'd1);
      chk("t2_data", 32'(rd_data), 32'hDE);
      pop_one();
      chk("t2_empty", 32'(empty), 32'd1);

      for (int i = 0; i < 16; i++)
         push_byte(8'(i));
      chk("t3_full", 32'(full), 32'd1);
      chk("t3_count", 32'(count), 32'd16);
      push_byte(8'hAA);
      chk("t3_ovf", 32'(ovf), 32'd1);
      chk("t3_cnt_ovf", 32'(count), 32'd16);
      for (int i = 0; i < 16; i++) begin
         chk("t3_seq", 32'(rd_data), 32'(i));
         pop_one();
      end
      chk("t3_drained", 32'(empty), 32'd1);

      for (int i = 0; i < 16; i++)
         push_byte(8'(i));
      rx_data = 8'h55;
      rx_rdy  = 1'b1;
      rd_en   = 1'b1;
      cyc();
      rx_rdy = 1'b0;
      rd_en  = 1'b0;
      cyc();
      chk("t4_count", 32'(count), 32'd16);
      for (int i = 1; i <= 16; i++) begin
         exp_b = (i == 16) ? 8'h55 : 8'(i);
         chk("t4_seq", 32'(rd_data), 32'(exp_b));
         pop_one();
      end

      ss = 1'b1;
      cyc();
      ss = 1'b0;
      cyc();
      push_byte(8'h90);
      push_byte(8'h3C);
      push_byte(8'h7F);
      ss = 1'b1;
      cyc();
      ss = 1'b0;
      cyc();
      push_byte(8'hB0);
`ifdef SPI_RX_FIFO_SOF_EN
      sof_pat = 4'b1001;
`else
      sof_pat = 4'b0000;
`endif
      for (int i = 0; i < 4; i++) begin
         chk("t5_sof", 32'(rd_sof), 32'(sof_pat[3-i]));
         pop_one();
      end
      ss = 1'b1;

      for (int i = 0; i < 16; i++)
         push_byte(8'(i + 32));
      rx_data = 8'hEE;
      rx_rdy  = 1'b1;
      ovf_clr = 1'b1;
      cyc();
      rx_rdy = 1'b0;
      chk("t6_set_wins", 32'(ovf), 32'd1);
      cyc();
      ovf_clr = 1'b0;
      chk("t6_clr", 32'(ovf), 32'd0);
      repeat (9) pop_one();
      chk("t6_count7", 32'(count), 32'd7);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("t6_rst_cnt", 32'(count), 32'd0);
      chk("t6_rst_empty", 32'(empty), 32'd1);

      for (int n = 0; n < 3000; n++) begin
         int bias;
         bias = ((n / 200) % 2 == 0) ? 25 : 75;
         if ($urandom_range(2) == 0)
            rx_rdy = ~rx_rdy;
         rx_data = 8'($urandom);
         rd_en   = ($urandom_range(99) < bias);
         if ($urandom_range(7) == 0)
            ss = ~ss;
         ovf_clr = ($urandom_range(19) == 0);
         rst_n   = ($urandom_range(299) != 0);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
